score_display: RTL and testbench

- Output-side counterpart of the button/score input path: the processor writes a score word, and this block drives a 4-digit multiplexed seven-segment display.
- A write latches a 32-bit value and clamps it to 9999.
- The value is converted to BCD by a sequential shift-add-3 (double-dabble) engine, one bit per cycle.
- The BCD value is shown on a time-multiplexed common-anode display with leading-zero blanking.

---
 rtl/score_display.sv | 104 ++++++++++
 tb/tb_score_display.sv | 114 +++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display: clamps a written score to 9999, converts it to BCD and scans it onto a 4-digit seven-segment display
module score_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] score_out,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;
  localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);
  state_t state, state_next;
  logic [13:0] value, bin, clamped;
  logic [15:0] bcd, adj, digits, scan;
  logic [3:0]  iter, digit;
  logic [1:0]  index;
  logic        blank;
  assign clamped = wdata > 32'd9999 ? 14'd9999 : wdata[13:0];
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  // next-state logic: a write is only accepted from IDLE, so writes during a conversion are dropped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = wren ? CONVERT : IDLE;
      CONVERT: state_next = iter == 4'd1 ? LOAD : CONVERT;
      default: state_next = IDLE;
    endcase
  end
  // FSM outputs
  always_comb
    busy = state != IDLE;
  // add-3 correction on every BCD nibble before each shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // conversion datapath; the display register only changes in LOAD so the old value stays shown meanwhile
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      bin <= '0;
      bcd <= '0;
      iter <= '0;
      digits <= '0;
      score_out <= '0;
    end else begin
      case (state)
        IDLE: if (wren) begin
          value <= clamped;
          bin <= clamped;
          bcd <= '0;
          iter <= 4'd14;
        end
        CONVERT: begin
          {bcd, bin} <= {adj, bin} << 1;
          iter <= iter - 4'd1;
        end
        LOAD: begin
          digits <= bcd;
          score_out <= {18'd0, value};
        end
        default: ;
      endcase
    end
  end
  // free-running scan: each digit stays lit for REFRESH_DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      scan <= '0;
      index <= '0;
    end else if (scan == LAST) begin
      scan <= '0;
      index <= index + 2'd1;
    end else
      scan <= scan + 16'd1;
  end
  // digit select, leading-zero blanking and active-low segment decode
  always_comb begin
    an = ~(4'b0001 << index);
    digit = digits[4*index +: 4];
    blank = index != 2'd0 && (digits >> {index, 2'b00}) == 16'd0;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    if (blank) seg = 7'b1111111;
  end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed stimulus against a cycle-level behavioural model of the score display
module tb_score_display;
  localparam int DIV = 4;
  logic clk = 0, reset = 1, wren = 0;
  logic [31:0] wdata = 0;
  logic busy;
  logic [31:0] score_out;
  logic [6:0] seg;
  logic [3:0] an;
  int checks = 0, errors = 0;
  score_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .wren(wren), .wdata(wdata),
    .busy(busy), .score_out(score_out), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  // model: displayed score, pending score, cycles left until it appears, scan tick
  int shown = 0, pending = 0, remaining = 0, tick = 0;
  bit started = 0;
  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};
  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      shown = 0; pending = 0; remaining = 0; tick = 0;
    end else begin
      tick++;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) shown = pending;
      end else if (wren) begin
        pending = wdata > 9999 ? 9999 : int'(wdata);
        remaining = 15;
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // every-cycle comparison against the model
  always @(negedge clk) if (started) begin
    int idx;
    logic [6:0] es;
    idx = (tick / DIV) % 4;
    es = (idx > 0 && shown < pow10[idx]) ? 7'b1111111 : segs[(shown / pow10[idx]) % 10];
    check("busy", {31'd0, busy}, {31'd0, remaining > 0});
    check("score_out", score_out, shown);
    check("an", {28'd0, an}, {28'd0, ~(4'b0001 << idx)});
    check("seg", {25'd0, seg}, {25'd0, es});
  end
  task automatic write(input logic [31:0] d);
    @(negedge clk); wren = 1; wdata = d;
    @(negedge clk); wren = 0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("busy_timeout", 1, 0);
  endtask
  task automatic wait_an(input logic [3:0] a);
    int n = 0;
    while (an !== a && n < 40) begin n++; @(negedge clk); end
    if (n >= 40) check("an_timeout", {28'd0, an}, {28'd0, a});
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hE);
    check("rst_seg", {25'd0, seg}, 32'h40);
    reset = 0;
    repeat (4) @(negedge clk);
    check("scan_an1", {28'd0, an}, 32'hD);
    check("scan_blank", {25'd0, seg}, 32'h7F);
    repeat (20) @(negedge clk);
    write(1234); wait_idle(n);
    check("busy_len", n, 15);
    check("lit_1234", score_out, 1234);
    wait_an(4'b1011); check("lit_1234_d2", {25'd0, seg}, 32'h24);
    write(32'hFFFFFFFF); wait_idle(n);
    check("lit_clamp", score_out, 9999);
    write(10000); wait_idle(n);
    check("lit_10000", score_out, 9999);
    wait_an(4'b0111); check("lit_9_d3", {25'd0, seg}, 32'h10);
    write(7); wait_idle(n);
    wait_an(4'b1110); check("lit_7_d0", {25'd0, seg}, 32'h78);
    wait_an(4'b1101); check("lit_7_d1", {25'd0, seg}, 32'h7F);
    write(1007); wait_idle(n);
    wait_an(4'b1011); check("lit_1007_d2", {25'd0, seg}, 32'h40);
    repeat (10) @(negedge clk);
    write(42);
    repeat (4) @(negedge clk);
    wren = 1; wdata = 99;
    @(negedge clk); wren = 0;
    wait_idle(n);
    check("drop_len", n, 10);
    check("lit_42", score_out, 42);
    repeat (20) @(negedge clk);
    write(5000);
    repeat (7) @(negedge clk);
    reset = 1;
    @(negedge clk); reset = 0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_score", score_out, 0);
    write(55); wait_idle(n);
    check("lit_55", score_out, 55);
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
